// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit (AND/OR/XOR/NOR/ANDN/PASS).
// Optional all-zero / all-one result flags are built when BITWISE_REDUCE_EN is defined.

module bitwise_lane (
  input  logic       a,
  input  logic       b,
  input  logic [2:0] op,
  output logic       y
);
  always_comb begin
    y = 1'b0;
    case (op)
      3'b000:  y = a & b;
      3'b001:  y = a | b;
      3'b010:  y = a ^ b;
      3'b011:  y = ~(a | b);
      3'b100:  y = a & ~b;
      3'b101:  y = a;
      default: y = 1'b0;
    endcase
  end
endmodule

module bitwise_logic_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_ones
);
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic [WIDTH-1:0] s1_a, s1_b, res;
  logic [2:0]       s1_op;
  logic             s2_load, in_fire;

  // An empty S2 always takes S1, so bubbles never block upstream.
  assign s2_load   = vld_pipe[1] && (!vld_pipe[2] || out_ready);
  assign in_ready  = !vld_pipe[1] || s2_load;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = vld_pipe[2];

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    bitwise_lane u_lane (.a(s1_a[i]), .b(s1_b[i]), .op(s1_op), .y(res[i]));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe[1] <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_op       <= '0;
    end else if (in_fire) begin
      vld_pipe[1] <= 1'b1;
      s1_a        <= num1;
      s1_b        <= num2;
      s1_op       <= op;
    end else if (s2_load) begin
      vld_pipe[1] <= 1'b0;
    end
  end

  // out only moves on s2_load, so it holds while stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe[2] <= 1'b0;
      out         <= '0;
    end else if (s2_load) begin
      vld_pipe[2] <= 1'b1;
      out         <= res;
    end else if (out_ready) begin
      vld_pipe[2] <= 1'b0;
    end
  end

`ifdef BITWISE_REDUCE_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_zero <= 1'b0;
      out_ones <= 1'b0;
    end else if (s2_load) begin
      out_zero <= ~|res;
      out_ones <= &res;
    end
  end
`else
  assign out_zero = 1'b0;
  assign out_ones = 1'b0;
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Bench for bitwise_logic_pipe: op-sweep table, handshake corner sequences and a random
// phase, run on WIDTH=32, 1 and 64 instances sharing one handshake.

module tb_bitwise_logic_pipe;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] num1 = '0, num2 = '0;
  logic [2:0]  op = '0;

  logic        in_ready32, in_ready1, in_ready64;
  logic        out_valid32, out_valid1, out_valid64;
  logic [31:0] out32;
  logic [0:0]  out1;
  logic [63:0] out64;
  logic        z32, o32, z1, o1, z64, o64;

  int checks = 0, failures = 0;

  always #5 clock = ~clock;

  bitwise_logic_pipe #(.WIDTH(32)) dut32 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready32),
    .num1(num1), .num2(num2), .op(op), .out_valid(out_valid32), .out_ready(out_ready),
    .out(out32), .out_zero(z32), .out_ones(o32));

  bitwise_logic_pipe #(.WIDTH(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .num1(num1[0]), .num2(num2[0]), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
    .out(out1), .out_zero(z1), .out_ones(o1));

  bitwise_logic_pipe #(.WIDTH(64)) dut64 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready64),
    .num1({num1, num1}), .num2({num2, num2}), .op(op), .out_valid(out_valid64),
    .out_ready(out_ready), .out(out64), .out_zero(z64), .out_ones(o64));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] a,
                                        input logic [63:0] b, input int w);
    logic [63:0] r;
    case (o)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a | b);
      3'd4:    r = a & ~b;
      3'd5:    r = a;
      default: r = '0;
    endcase
    return r & mask(w);
  endfunction

  // {ones, zero}
  function automatic logic [1:0] flags(input logic [63:0] r, input int w);
`ifdef BITWISE_REDUCE_EN
    return {r == mask(w), r == 64'd0};
`else
    return {1'b0, 1'b0 & r[0] & (w > 0)};
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every accepted beat must come out once, in order, on all three widths.
  typedef struct { logic [2:0] op; logic [31:0] a, b; } beat_t;
  beat_t       q[$];
  beat_t       bt;
  logic        stall = 1'b0;
  logic [31:0] held;
  logic [63:0] e32, e64, e1;

  always @(negedge clock) begin
    if (!reset_n) begin
      q.delete();
      stall = 1'b0;
    end else begin
      chk("agree_in_ready", {in_ready1, in_ready64}, {in_ready32, in_ready32});
      chk("agree_out_valid", {out_valid1, out_valid64}, {out_valid32, out_valid32});
      if (stall && out_valid32) chk("hold_out", out32, held);
      if (out_valid32 && out_ready) begin
        if (q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          bt  = q.pop_front();
          e32 = model(bt.op, bt.a, bt.b, 32);
          e64 = model(bt.op, {bt.a, bt.a}, {bt.b, bt.b}, 64);
          e1  = model(bt.op, bt.a, bt.b, 1);
          chk("sb_out32", out32, e32);
          chk("sb_out64", out64, e64);
          chk("sb_out1", out1, e1);
          chk("sb_flags32", {o32, z32}, flags(e32, 32));
          chk("sb_flags64", {o64, z64}, flags(e64, 64));
          chk("sb_flags1", {o1, z1}, flags(e1, 1));
        end
      end
      stall = out_valid32 && !out_ready;
      held  = out32;
      if (in_valid && in_ready32) q.push_back('{op, num1, num2});
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    logic [1:0]  fl;  // {ones, zero} when the reduction flags are built
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[9];
    logic [31:0] a0, a1, a2, bb, first;

    tbl[0] = '{3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 2'b00};
    tbl[1] = '{3'b001, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 2'b00};
    tbl[2] = '{3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 2'b00};
    tbl[3] = '{3'b011, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h000F_0000, 2'b00};
    tbl[4] = '{3'b100, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hF000_0000, 2'b00};
    tbl[5] = '{3'b101, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hF0F0_1234, 2'b00};
    tbl[6] = '{3'b111, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0000_0000, 2'b01};
    tbl[7] = '{3'b010, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 2'b01};
    tbl[8] = '{3'b011, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 2'b10};

    // Reset state
    @(negedge clock);
    chk("rst_out_valid", out_valid32, 0);
    chk("rst_out", out32, 0);
    chk("rst_flags", {o32, z32}, 0);
    tick();
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", in_ready32, 1);
    tick();

    // Op sweep with latency check
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; num1 = tbl[i].a; num2 = tbl[i].b; op = tbl[i].op; out_ready = 1'b1;
      @(negedge clock);
      chk("sw_in_ready", in_ready32, 1);
      tick();
      in_valid = 1'b0; op = 3'($urandom); num1 = $urandom; num2 = $urandom;
      @(negedge clock);
      chk("sw_early_valid", out_valid32, 0);
      tick();
      @(negedge clock);
      chk("sw_valid", out_valid32, 1);
      chk("sw_out", out32, tbl[i].exp);
`ifdef BITWISE_REDUCE_EN
      chk("sw_flags", {o32, z32}, tbl[i].fl);
`else
      chk("sw_flags", {o32, z32}, 2'b00);
`endif
      tick();
    end

    // Back-to-back throughput
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        in_valid = 1'b1; op = 3'b001; num1 = $urandom; num2 = $urandom;
      end else in_valid = 1'b0;
      @(negedge clock);
      if (k < 8) chk("tp_in_ready", in_ready32, 1);
      chk("tp_out_valid", out_valid32, (k >= 2 && k <= 9));
      tick();
    end

    // Backpressure: 3 beats offered with the consumer stalled
    bb = 32'h0000_00FF; a0 = 32'h1111_0000; a1 = 32'h2222_0000; a2 = 32'h3333_0000;
    out_ready = 1'b0; in_valid = 1'b1; op = 3'b001; num2 = bb; num1 = a0;
    @(negedge clock); chk("bp_rdy0", in_ready32, 1); tick(); num1 = a1;
    @(negedge clock); chk("bp_rdy1", in_ready32, 1); tick(); num1 = a2;
    @(negedge clock);
    chk("bp_rdy2", in_ready32, 0);
    chk("bp_valid", out_valid32, 1);
    chk("bp_out", out32, model(3'b001, a0, bb, 32));
    first = out32;
    tick();
    @(negedge clock);
    chk("bp_rdy3", in_ready32, 0);
    chk("bp_hold", out32, first);
    tick();
    out_ready = 1'b1;
    @(negedge clock); chk("bp_rdy4", in_ready32, 1); tick();
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clock); chk("bp_drained", q.size(), 0);
    tick();

    // Reset with two beats in flight
    out_ready = 1'b0; in_valid = 1'b1; op = 3'b010; num1 = $urandom; num2 = $urandom;
    tick(); num1 = $urandom;
    tick(); in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    chk("mrst_out_valid", out_valid32, 0);
    chk("mrst_out", out32, 0);
    tick();
    reset_n = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    chk("mrst_in_ready", in_ready32, 1);
    chk("mrst_valid_after", out_valid32, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clock);
      chk("mrst_no_stale", out_valid32, 0);
    end
    tick();

    // Random handshake and operands
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom);
      num1      = $urandom;
      num2      = ($urandom_range(0, 7) == 0) ? num1 : $urandom;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    @(negedge clock);
    chk("final_drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bitwise_logic_pipe.md
# bitwise_logic_pipe

Parametrised, pipelined bitwise logic unit. It generalises the fixed 32-bit OR to a WIDTH-bit datapath with a selectable operation (AND, OR, XOR, NOR, ANDN, pass-through). It uses a two-stage registered pipeline with a valid/ready handshake on both sides. It sits in the ALU logic cluster beside the adder and shifter and feeds the execute-stage result mux.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 1)
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  unit accepts beat this cycle
- num1  input  WIDTH  operand A
- num2  input  WIDTH  operand B
- op  input  3  operation select, sampled with the beat
- out_valid  output  1  result beat offered
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  result
- out_zero  output  1  result is all zeros (BITWISE_REDUCE_EN only)
- out_ones  output  1  result is all ones (BITWISE_REDUCE_EN only)

## Operation
- Opcodes:
  - 3'b000 AND: num1 & num2
  - 3'b001 OR: num1 | num2
  - 3'b010 XOR: num1 ^ num2
  - 3'b011 NOR: ~(num1 | num2)
  - 3'b100 ANDN: num1 & ~num2
  - 3'b101 PASS: num1
  - 3'b110, 3'b111 reserved: result 0
- Stage 1 (S1) registers num1, num2 and op, plus s1_valid.
- Stage 2 (S2) registers the computed result (and flags), plus s2_valid. out, out_valid, out_zero and out_ones come directly from S2 flops.
- A transfer occurs when valid && ready are high on the same rising edge, on either side.
- S2 advance: s2_load = s1_valid && (!s2_valid || out_ready).
- S1 advance: in_ready = !s1_valid || s2_load. This is combinational from out_ready and state only; it never depends on in_valid.
- Bubbles collapse: an empty stage always accepts, regardless of downstream ready.
- While out_valid && !out_ready, out, out_zero and out_ones hold stable.
- Pipeline holds at most 2 beats. When both stages are full and out_ready is low, in_ready is 0.
- No width conversion. All operations are strictly bitwise over WIDTH bits; no carry and no overflow.
- Reset (asynchronous assert, synchronous release via the clock edge):
  - s1_valid = 0, s2_valid = 0, so out_valid = 0
  - out = 0, out_zero = 0, out_ones = 0
  - S1 data registers = 0
  - in_ready reads 1 once reset_n = 1
- Reset asserted mid-operation discards all in-flight beats; no partial output is presented.

## Timing
- Latency: a beat accepted at edge N presents out_valid at edge N+2, given out_ready was high or S2 was empty at edge N+1.
- Throughput: one beat per cycle while out_ready stays high.
- Simultaneous events:
  - Full pipe with out_ready = 1 and in_valid = 1: S2 drains, S1 moves to S2 and the new beat enters S1, all on the same edge. No lost or duplicated beat.
  - S2 full and stalled, S1 empty: one more beat is accepted into S1, then in_ready drops.
- op is captured only on accepted beats. Changing op without in_valid has no effect.

## Configuration
- BITWISE_REDUCE_EN defined:
  - S2 also registers out_zero = ~|result and out_ones = &result, computed from the S2 input.
  - The flags are aligned with out and obey the same hold rules.
- BITWISE_REDUCE_EN undefined:
  - out_zero and out_ones are tied to 0.
  - No reduction logic or flops are synthesised.
- Datapath and handshake behaviour are identical in both builds.

## Test plan
- Reset check: assert reset_n = 0 mid-stream with two beats in flight, then release. Required: out_valid = 0, out = 0, in_ready = 1 on the first post-reset cycle, and no stale beat ever appears.
- Op sweep (WIDTH = 32, out_ready = 1): num1 = 32'hF0F0_1234, num2 = 32'h0FF0_FFFF.
  - AND → 32'h00F0_1234
  - OR → 32'hFFF0_FFFF
  - XOR → 32'hFF00_EDCB
  - NOR → 32'h000F_0000
  - ANDN → 32'hF000_0000
  - PASS → 32'hF0F0_1234
  - op = 3'b111 → 0
  - Each result must appear exactly 2 cycles after acceptance.
- Back-to-back throughput: 8 consecutive OR beats with out_ready = 1. Required: 8 results on 8 consecutive cycles, in order, with in_ready held at 1.
- Backpressure: hold out_ready = 0 while offering 3 beats. Required:
  - 2 beats are accepted, then in_ready = 0.
  - out holds the first result stable.
  - Raising out_ready drains all 3 in order with no loss or duplication.
- Reduction flags (BITWISE_REDUCE_EN):
  - XOR of 32'hA5A5_A5A5 with itself → out_zero = 1, out_ones = 0.
  - NOR of 0 with 0 → out_ones = 1, out_zero = 0.
  - Without the macro, both flags stay 0.
- Parametrisation: rerun the op sweep at WIDTH = 1 and WIDTH = 64 (operands replicated or truncated). Required: bitwise results match a reference model on every beat.
